// File: rtl/latch_arb_pkg.sv
// Shared definitions for the 7475 quad-latch write arbiter.
//   state_t      : sequencer states (IDLE, SETUP, ENABLE, HOLD)
//   SEL_C12/C34  : half select values (0 = d1/d2 via c12, 1 = d3/d4 via c34)
//   merge_pair   : replaces one 2-bit half of a {q4,q3,q2,q1} word
package latch_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ENABLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic SEL_C12 = 1'b0;
  localparam logic SEL_C34 = 1'b1;

  // Write 'data' into the half chosen by 'half'; the other half is kept.
  function automatic logic [3:0] merge_pair(input logic [3:0] cur,
                                            input logic       half,
                                            input logic [1:0] data);
    return (half == SEL_C34) ? {data, cur[1:0]} : {cur[3:2], data};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : index of the last granted requester; search starts at ptr+1
//   grant     : one-hot grant (zero when no request)
//   grant_idx : binary index of the granted requester
//   any_req   : at least one request is pending
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any_req
);

  logic found;
  int   cand;

  always_comb begin
    found     = 1'b0;
    cand      = 0;
    grant_idx = '0;
    // Walk ptr+1, ptr+2, ... wrapping; first requester found wins.
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!found && req[cand[IW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
    grant   = found ? (NREQ'(1) << grant_idx) : '0;
    any_req = |req;
  end

endmodule

// File: rtl/latch_7475_arbiter.sv
// Round-robin write arbiter in front of a 7475-style quad latch.
// Each granted write runs IDLE -> SETUP -> ENABLE (PULSE_CYCLES) -> HOLD so
// the selected half sees stable D before, during and after its enable.
//   clk, rst_n      : clock, asynchronous active-low reset
//   req/sel/wdata   : per-requester request, half select, 2-bit data
//   ack             : one-cycle completion pulse to the granted requester
//   busy            : high whenever the sequencer is not idle
//   d1..d4, c12,c34 : registered latch data and enables
//   shadow_q        : {q4,q3,q2,q1} copy of the latch contents when the
//                     LATCH_ARB_SHADOW_EN macro is defined, else 4'b0000
module latch_7475_arbiter
  import latch_arb_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int PULSE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   sel,
  input  logic [2*NREQ-1:0] wdata,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic              d1,
  output logic              d2,
  output logic              d3,
  output logic              d4,
  output logic              c12,
  output logic              c34,
  output logic [3:0]        shadow_q
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(PULSE_CYCLES + 1);

  logic [1:0] wdata_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_split
      assign wdata_arr[gi] = wdata[2*gi +: 2];
    end
  endgenerate

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  state_t          state_reg;
  logic [IW-1:0]   ptr_reg;
  logic [IW-1:0]   gidx_reg;
  logic [NREQ-1:0] gonehot_reg;
  logic            sel_reg;
  logic [CW-1:0]   cnt_reg;
  logic [3:0]      d_reg;      // {d4,d3,d2,d1}
  logic            c12_reg;
  logic            c34_reg;
  logic [NREQ-1:0] ack_reg;
  logic            busy_reg;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (req),
    .ptr       (ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // Outputs are registered on the transition into each state, so the
  // visible d/c/ack/busy values always describe the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= IW'(NREQ - 1);
      gidx_reg    <= '0;
      gonehot_reg <= '0;
      sel_reg     <= SEL_C12;
      cnt_reg     <= '0;
      d_reg       <= '0;
      c12_reg     <= 1'b0;
      c34_reg     <= 1'b0;
      ack_reg     <= '0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arb_any) begin
            // Capture everything at grant; later input changes are ignored.
            gidx_reg    <= arb_idx;
            gonehot_reg <= arb_grant;
            sel_reg     <= sel[arb_idx];
            d_reg       <= merge_pair(d_reg, sel[arb_idx], wdata_arr[arb_idx]);
            busy_reg    <= 1'b1;
            state_reg   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (sel_reg == SEL_C34) c34_reg <= 1'b1;
          else                    c12_reg <= 1'b1;
          cnt_reg   <= CW'(PULSE_CYCLES);
          state_reg <= ST_ENABLE;
        end
        ST_ENABLE: begin
          if (cnt_reg == CW'(1)) begin
            c12_reg   <= 1'b0;
            c34_reg   <= 1'b0;
            ack_reg   <= gonehot_reg;
            state_reg <= ST_HOLD;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        ST_HOLD: begin
          ack_reg   <= '0;
          busy_reg  <= 1'b0;
          ptr_reg   <= gidx_reg;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef LATCH_ARB_SHADOW_EN
  logic [3:0] shadow_reg;

  // Updated on the edge that leaves HOLD, i.e. visible the cycle after ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg <= '0;
    end else if (state_reg == ST_HOLD) begin
      shadow_reg <= merge_pair(shadow_reg, sel_reg,
                               (sel_reg == SEL_C34) ? d_reg[3:2] : d_reg[1:0]);
    end
  end

  assign shadow_q = shadow_reg;
`else
  assign shadow_q = 4'b0000;
`endif

  assign d1   = d_reg[0];
  assign d2   = d_reg[1];
  assign d3   = d_reg[2];
  assign d4   = d_reg[3];
  assign c12  = c12_reg;
  assign c34  = c34_reg;
  assign ack  = ack_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_latch_7475_arbiter.sv
// Self-checking bench for latch_7475_arbiter (NREQ=2, PULSE_CYCLES=2).
// Honours LATCH_ARB_SHADOW_EN for the expected shadow_q.
module tb_latch_7475_arbiter;

  localparam int NREQ = 2;
  localparam int P    = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] sel = '0;
  logic [3:0]      wdata = '0;
  logic [NREQ-1:0] ack;
  logic            busy, d1, d2, d3, d4, c12, c34;
  logic [3:0]      shadow_q;

  int checks = 0;
  int failures = 0;

  latch_7475_arbiter #(.NREQ(NREQ), .PULSE_CYCLES(P)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .sel(sel), .wdata(wdata),
    .ack(ack), .busy(busy), .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .c12(c12), .c34(c34), .shadow_q(shadow_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A transaction is a phase count from its grant edge: phase 1 = setup,
  // 2..P+1 = enable, P+2 = ack, P+3 = back to idle.
  bit         m_active;
  int         m_ph, m_idx, m_ptr;
  bit         m_sel;
  logic [1:0] m_data;
  logic [3:0] m_d, m_sh;

  always @(posedge clk) begin
    logic [NREQ-1:0] e_ack;
    if (!rst_n) begin
      m_active = 0; m_ph = 0; m_ptr = NREQ - 1; m_d = '0; m_sh = '0; m_idx = 0; m_sel = 0;
    end else if (m_active) begin
      m_ph++;
      if (m_ph == P + 3) begin
        m_active = 0;
        m_ptr = m_idx;
`ifdef LATCH_ARB_SHADOW_EN
        if (m_sel) m_sh[3:2] = m_data; else m_sh[1:0] = m_data;
`endif
      end
    end else if (|req) begin
      for (int k = NREQ; k >= 1; k--) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (req[i]) m_idx = i;   // descending scan leaves the nearest one
      end
      m_sel    = sel[m_idx];
      m_data   = wdata[2*m_idx +: 2];
      m_active = 1;
      m_ph     = 1;
      if (m_sel) m_d[3:2] = m_data; else m_d[1:0] = m_data;
    end
    #1;
    e_ack = (m_active && m_ph == P + 2) ? NREQ'(1 << m_idx) : '0;
    check("m_busy", 8'(busy), 8'(m_active));
    check("m_c12", 8'(c12), 8'(m_active && m_ph >= 2 && m_ph <= P + 1 && !m_sel));
    check("m_c34", 8'(c34), 8'(m_active && m_ph >= 2 && m_ph <= P + 1 && m_sel));
    check("m_ack", 8'(ack), 8'(e_ack));
    check("m_d", 8'({d4, d3, d2, d1}), 8'(m_d));
    check("m_shadow", 8'(shadow_q), 8'(m_sh));
  end

  // ---------------- directed stimulus ----------------
  task automatic do_write(input logic [1:0] r, input logic [1:0] s, input logic [3:0] w,
                          input logic [1:0] exp_ack, input bit iso);
    bit got;
    got = 0;
    req = r; sel = s; wdata = w;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (iso) begin
        check("iso_d3", 8'(d3), 8'd1);
        check("iso_d4", 8'(d4), 8'd1);
        check("iso_c34", 8'(c34), 8'd0);
      end
      if (ack != '0) begin
        got = 1;
        check("wr_ack", 8'(ack), 8'(exp_ack));
        req = '0;
      end
    end
    if (!got) check("wr_timeout", 8'd0, 8'd1);
    @(negedge clk);
  endtask

  int         ack_cyc [4];
  logic [1:0] ack_val [4];

  initial begin
    int  nack;
    bit  got;
    // Power-on reset
    repeat (3) @(negedge clk);
    check("rst_d", 8'({d4, d3, d2, d1}), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_ack", 8'(ack), 8'd0);
    check("rst_c", 8'({c34, c12}), 8'd0);
    check("rst_shadow", 8'(shadow_q), 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write: requester 0, c12 half, data 2'b10
    req = 2'b01; sel = 2'b00; wdata = 4'b0010;
    @(negedge clk);
    check("single_setup_d", 8'({d2, d1}), 8'b10);
    check("single_setup_c12", 8'(c12), 8'd0);
    check("single_busy", 8'(busy), 8'd1);
    @(negedge clk);
    check("single_c12_a", 8'(c12), 8'd1);
    @(negedge clk);
    check("single_c12_b", 8'(c12), 8'd1);
    @(negedge clk);
    check("single_ack", 8'(ack), 8'b01);
    check("single_c12_off", 8'(c12), 8'd0);
    req = '0;
    @(negedge clk);
    check("single_ack_clr", 8'(ack), 8'd0);
    check("single_idle", 8'(busy), 8'd0);

    // Contention: pointer now at 0, so requester 1 goes first
    req = 2'b11; sel = 2'b10; wdata = 4'b0110;
    nack = 0;
    for (int n = 0; n < 60 && nack < 4; n++) begin
      @(negedge clk);
      if (ack != '0) begin
        ack_val[nack] = ack;
        ack_cyc[nack] = n;
        nack++;
        if (nack == 4) req = '0;
      end
    end
    check("cont_count", 8'(nack), 8'd4);
    if (nack == 4) begin
      check("cont_ack0", 8'(ack_val[0]), 8'b10);
      check("cont_ack1", 8'(ack_val[1]), 8'b01);
      check("cont_ack2", 8'(ack_val[2]), 8'b10);
      check("cont_ack3", 8'(ack_val[3]), 8'b01);
      for (int i = 0; i < 3; i++)
        check("cont_spacing", 8'(ack_cyc[i+1] - ack_cyc[i]), 8'(P + 3));
    end
    @(negedge clk);

    // Pair isolation: 2'b11 into c34 half, then 2'b01 into c12 half
    do_write(2'b01, 2'b01, 4'b0011, 2'b01, 0);
    do_write(2'b10, 2'b00, 4'b0100, 2'b10, 1);
    check("iso_d", 8'({d4, d3, d2, d1}), 8'b1101);

    // Capture: change sel/wdata and drop req right after grant
    req = 2'b10; sel = 2'b10; wdata = 4'b1100;
    @(negedge clk);
    req = 2'b00; sel = 2'b00; wdata = 4'b0000;
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (ack != '0) begin
        got = 1;
        check("cap_ack", 8'(ack), 8'b10);
      end
    end
    if (!got) check("cap_ack_timeout", 8'd0, 8'd1);
    @(negedge clk);
    check("cap_d", 8'({d4, d3, d2, d1}), 8'b1101);
`ifdef LATCH_ARB_SHADOW_EN
    check("shadow_val", 8'(shadow_q), 8'b1101);
`else
    check("shadow_val", 8'(shadow_q), 8'b0000);
`endif

    // Asynchronous reset in the middle of an enable pulse
    req = 2'b01; sel = 2'b00; wdata = 4'b0011;
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (c12) got = 1;
    end
    check("arst_c12_seen", 8'(got), 8'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_c12", 8'(c12), 8'd0);
    check("arst_d", 8'({d4, d3, d2, d1}), 8'd0);
    check("arst_ack", 8'(ack), 8'd0);
    check("arst_busy", 8'(busy), 8'd0);
    check("arst_shadow", 8'(shadow_q), 8'd0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    got = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ack != '0) got = 1;
    end
    check("arst_no_ack", 8'(got), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
